// File: rtl/speed_governor.sv
// -----------------------------------------------------------------------------
// speed_governor
//
// Closed-loop speed governor. The applied accelerate and brake forces are
// integrated into a registered speed value. A four-state controller pushes that
// speed toward a programmable threshold. It uses a hysteresis band around the
// threshold, clamps both forces to MAX_FORCE, and saturates all arithmetic so
// that nothing wraps.
//
// Parameters
//   W          width of the speed, threshold, request and force buses
//   STEP       boost added to af_req while accelerating
//   HYST       half-width of the cruise band around threshold
//   MAX_FORCE  upper clamp on o_af / o_bf (must be <= 2**W-1)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset (overrides en)
//   en         governor enable; low forces IDLE and freezes speed
//   threshold  target speed
//   af_req     driver accelerate request
//   bf_req     driver brake request
//   speed      registered integrated speed
//   o_af       registered accelerate force
//   o_bf       registered brake force
//   state      00 IDLE, 01 ACCEL, 10 CRUISE, 11 BRAKE
//   at_target  high while state is CRUISE
//
// State table
//   state  | meaning
//   IDLE   | governor disabled or in reset; forces zero, speed frozen
//   ACCEL  | speed below the band; accelerate force applied
//   CRUISE | speed inside [lo, hi]; no force applied
//   BRAKE  | speed above the band; brake force applied
// -----------------------------------------------------------------------------
module speed_governor #(
   parameter int W         = 8,
   parameter int STEP      = 10,
   parameter int HYST      = 4,
   parameter int MAX_FORCE = 20
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] threshold,
   input  logic [W-1:0] af_req,
   input  logic [W-1:0] bf_req,
   output logic [W-1:0] speed,
   output logic [W-1:0] o_af,
   output logic [W-1:0] o_bf,
   output logic [1:0]   state,
   output logic         at_target
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCEL  = 2'b01,
      ST_CRUISE = 2'b10,
      ST_BRAKE  = 2'b11
   } state_t;

   localparam logic [W:0] SPD_MAX_W = {1'b0, {W{1'b1}}};
   localparam logic [W:0] HYST_W    = (W+1)'(HYST);
   localparam logic [W:0] STEP_W    = (W+1)'(STEP);
   localparam logic [W:0] MAXF_W    = (W+1)'(MAX_FORCE);

   state_t state_r;

   // -------------------------------------------------------------------------
   // Integration: speed + o_af - o_bf evaluated in W+2 signed bits.
   // Bit W+1 is the sign bit, so a set bit means the result went below zero.
   // Bit W set on a non-negative result means it passed 2**W-1. The widest
   // positive value, 2*(2**W-1), cannot reach bit W+1.
   // -------------------------------------------------------------------------
   logic signed [W+1:0] sum_s;
   logic [W-1:0]        s_n;

   always_comb begin
      sum_s = $signed({2'b00, speed}) + $signed({2'b00, o_af})
            - $signed({2'b00, o_bf});
      if (sum_s[W+1])
         s_n = '0;
      else if (sum_s[W])
         s_n = {W{1'b1}};
      else
         s_n = sum_s[W-1:0];
   end

   // -------------------------------------------------------------------------
   // Cruise band [lo, hi], clamped to the representable speed range.
   // -------------------------------------------------------------------------
   logic [W:0] thr_w;
   logic [W:0] lo_w;
   logic [W:0] hi_sum;
   logic [W:0] hi_w;

   always_comb begin
      thr_w  = {1'b0, threshold};
      lo_w   = (thr_w < HYST_W) ? '0 : (thr_w - HYST_W);
      hi_sum = thr_w + HYST_W;
      hi_w   = (hi_sum > SPD_MAX_W) ? SPD_MAX_W : hi_sum;
   end

   // -------------------------------------------------------------------------
   // Candidate forces. The brake difference is used only when s_n > hi, and
   // hi is never below threshold, so s_n - threshold cannot underflow when it
   // is selected.
   // -------------------------------------------------------------------------
   logic [W:0]   af_sum;
   logic [W-1:0] af_next;
   logic [W-1:0] over_thr;
   logic [W:0]   bf_sum;
   logic [W-1:0] bf_next;

   always_comb begin
      af_sum   = {1'b0, af_req} + STEP_W;
      af_next  = (af_sum > MAXF_W) ? MAXF_W[W-1:0] : af_sum[W-1:0];
      over_thr = s_n - threshold;
      bf_sum   = {1'b0, over_thr} + {1'b0, bf_req};
      bf_next  = (bf_sum > MAXF_W) ? MAXF_W[W-1:0] : bf_sum[W-1:0];
   end

   logic below_band;
   logic above_band;

   always_comb begin
      below_band = ({1'b0, s_n} < lo_w);
      above_band = ({1'b0, s_n} > hi_w);
   end

   // -------------------------------------------------------------------------
   // Controller. It classifies the speed being written this edge, not the
   // old speed, so state, forces and speed always agree after the edge.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         speed     <= '0;
         o_af      <= '0;
         o_bf      <= '0;
         state_r   <= ST_IDLE;
         at_target <= 1'b0;
      end else if (!en) begin
         o_af      <= '0;
         o_bf      <= '0;
         state_r   <= ST_IDLE;
         at_target <= 1'b0;
      end else begin
         speed <= s_n;
         if (below_band) begin
            state_r   <= ST_ACCEL;
            o_af      <= af_next;
            o_bf      <= '0;
            at_target <= 1'b0;
         end else if (above_band) begin
            state_r   <= ST_BRAKE;
            o_af      <= '0;
            o_bf      <= bf_next;
            at_target <= 1'b0;
         end else begin
            state_r   <= ST_CRUISE;
            o_af      <= '0;
            o_bf      <= '0;
            at_target <= 1'b1;
         end
      end
   end

   assign state = state_r;

endmodule

// File: tb/tb_speed_governor.sv
module tb_speed_governor;

   localparam int W         = 8;
   localparam int STEP      = 10;
   localparam int HYST      = 4;
   localparam int MAX_FORCE = 20;
   localparam int SMAX      = (1 << W) - 1;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         en = 1'b0;
   logic [W-1:0] threshold = '0;
   logic [W-1:0] af_req = '0;
   logic [W-1:0] bf_req = '0;
   logic [W-1:0] speed;
   logic [W-1:0] o_af;
   logic [W-1:0] o_bf;
   logic [1:0]   state;
   logic         at_target;

   int n_checks = 0;
   int n_errors = 0;

   speed_governor #(.W(W), .STEP(STEP), .HYST(HYST), .MAX_FORCE(MAX_FORCE)) dut (
      .clk(clk), .rst(rst), .en(en), .threshold(threshold),
      .af_req(af_req), .bf_req(bf_req), .speed(speed), .o_af(o_af),
      .o_bf(o_bf), .state(state), .at_target(at_target)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL timeout: simulation did not finish, got time %0t want < 5ms", $time);
      $fatal(1, "timeout");
   end

   typedef struct {
      bit rst;
      bit en;
      int thr;
      int af;
      int bf;
      int e_spd;
      int e_af;
      int e_bf;
      int e_st;
   } vec_t;

   vec_t vecs[$];

   // Reference model state: 0 IDLE, 1 ACCEL, 2 CRUISE, 3 BRAKE
   int m_spd, m_af, m_bf, m_st;

   task automatic model_step(input bit r, input bit e, input int thr, input int afr, input int bfr);
      int s, lo, hi;
      if (r) begin
         m_spd = 0; m_af = 0; m_bf = 0; m_st = 0;
      end else if (!e) begin
         m_af = 0; m_bf = 0; m_st = 0;
      end else begin
         s  = m_spd + m_af - m_bf;
         if (s < 0) s = 0;
         if (s > SMAX) s = SMAX;
         lo = (thr - HYST < 0) ? 0 : thr - HYST;
         hi = (thr + HYST > SMAX) ? SMAX : thr + HYST;
         m_spd = s;
         if (s < lo) begin
            m_st = 1; m_bf = 0;
            m_af = (afr + STEP > MAX_FORCE) ? MAX_FORCE : afr + STEP;
         end else if (s > hi) begin
            m_st = 3; m_af = 0;
            m_bf = (s - thr + bfr > MAX_FORCE) ? MAX_FORCE : s - thr + bfr;
         end else begin
            m_st = 2; m_af = 0; m_bf = 0;
         end
      end
   endtask

   task automatic tick(input bit r, input bit e, input int thr, input int afr, input int bfr);
      rst       = r;
      en        = e;
      threshold = W'(thr);
      af_req    = W'(afr);
      bf_req    = W'(bfr);
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int es, input int ea, input int eb, input int est);
      n_checks++;
      if (speed !== W'(es) || o_af !== W'(ea) || o_bf !== W'(eb) ||
          state !== 2'(est) || at_target !== (est == 2)) begin
         n_errors++;
         $display("FAIL %s: got speed=%0d af=%0d bf=%0d state=%0d at=%0b, want speed=%0d af=%0d bf=%0d state=%0d at=%0b",
                  name, speed, o_af, o_bf, state, at_target, es, ea, eb, est, (est == 2));
      end
   endtask

   // Reset, then ramp to exactly x with forces in [STEP, MAX_FORCE], then
   // park there in CRUISE by setting threshold = x.
   task automatic preload(input int x);
      int r, f;
      tick(1, 0, 0, 0, 0);
      r = x;
      while (r > 0) begin
         if (r >= 40)      f = 20;
         else if (r >= 30) f = r - 20;
         else if (r > 20)  f = 10;
         else              f = r;
         tick(0, 1, 255, f - STEP, 0);
         r -= f;
      end
      tick(0, 1, x, 0, 0);
      check($sformatf("preload_%0d", x), x, 0, 0, 2);
   endtask

   initial begin
      // ---------------- table: reset, ramp, braking, enable drop ----------
      vecs.push_back('{1, 0, 0,   0, 0, 0,   0,  0,  0});
      vecs.push_back('{1, 1, 100, 0, 0, 0,   0,  0,  0});
      vecs.push_back('{0, 1, 100, 0, 0, 0,   10, 0,  1});
      for (int k = 1; k <= 9; k++)
         vecs.push_back('{0, 1, 100, 0, 0, 10 * k, 10, 0, 1});
      vecs.push_back('{0, 1, 100, 0, 0, 100, 0,  0,  2});
      vecs.push_back('{0, 1, 100, 0, 0, 100, 0,  0,  2});
      vecs.push_back('{0, 1, 60,  0, 0, 100, 0,  20, 3});
      vecs.push_back('{0, 1, 60,  0, 0, 80,  0,  20, 3});
      vecs.push_back('{0, 1, 60,  0, 0, 60,  0,  0,  2});
      vecs.push_back('{0, 0, 60,  0, 0, 60,  0,  0,  0});
      vecs.push_back('{0, 1, 60,  0, 0, 60,  0,  0,  2});

      for (int i = 0; i < vecs.size(); i++) begin
         tick(vecs[i].rst, vecs[i].en, vecs[i].thr, vecs[i].af, vecs[i].bf);
         check($sformatf("vec%0d", i), vecs[i].e_spd, vecs[i].e_af, vecs[i].e_bf, vecs[i].e_st);
      end

      // ---------------- clamp and saturation at the top -------------------
      preload(250);
      tick(0, 1, 255, 15, 0);
      check("af_clamp", 250, 20, 0, 1);
      tick(0, 1, 255, 15, 0);
      check("spd_sat_hi", 255, 0, 0, 2);

      // ---------------- saturation at zero --------------------------------
      preload(10);
      tick(0, 1, 0, 0, 30);
      check("brake_low", 10, 0, 20, 3);
      tick(0, 1, 0, 0, 30);
      check("spd_sat_lo", 0, 0, 0, 2);

      // ---------------- hysteresis around 100 -----------------------------
      preload(97);
      tick(0, 1, 100, 0, 0);
      check("hyst_97", 97, 0, 0, 2);
      preload(104);
      tick(0, 1, 100, 0, 0);
      check("hyst_104", 104, 0, 0, 2);
      preload(96);
      tick(0, 1, 100, 0, 0);
      check("hyst_96_lo", 96, 0, 0, 2);
      preload(95);
      tick(0, 1, 100, 3, 0);
      check("hyst_95", 95, 13, 0, 1);
      preload(105);
      tick(0, 1, 100, 0, 2);
      check("hyst_105", 105, 0, 7, 3);
      preload(105);
      tick(0, 1, 100, 0, 30);
      check("hyst_105_clamp", 105, 0, 20, 3);

      // ---------------- low threshold, enable drop mid-ramp ---------------
      tick(1, 0, 0, 0, 0);
      tick(0, 1, 2, 0, 0);
      check("low_thr", 0, 0, 0, 2);
      tick(1, 0, 0, 0, 0);
      for (int k = 0; k < 5; k++) tick(0, 1, 255, 0, 0);
      check("ramp_40", 40, 10, 0, 1);
      tick(0, 0, 255, 0, 0);
      check("en_drop", 40, 0, 0, 0);
      tick(0, 0, 255, 0, 0);
      check("en_low_hold", 40, 0, 0, 0);
      tick(0, 1, 255, 0, 0);
      check("leave_idle", 40, 10, 0, 1);

      // ---------------- reset in BRAKE ------------------------------------
      preload(100);
      tick(0, 1, 60, 0, 0);
      check("brake_pre_rst", 100, 0, 20, 3);
      tick(1, 1, 60, 0, 0);
      check("rst_mid", 0, 0, 0, 0);

      // ---------------- randomized against the reference model ------------
      tick(1, 0, 0, 0, 0);
      model_step(1, 0, 0, 0, 0);
      for (int i = 0; i < 3000; i++) begin
         bit r, e;
         int thr, afr, bfr;
         r   = ($urandom_range(0, 99) < 2);
         e   = ($urandom_range(0, 99) < 90);
         case ($urandom_range(0, 3))
            0:       thr = $urandom_range(0, 6);
            1:       thr = $urandom_range(249, 255);
            default: thr = $urandom_range(0, 255);
         endcase
         afr = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 15) : $urandom_range(0, 255);
         bfr = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 15) : $urandom_range(0, 255);
         tick(r, e, thr, afr, bfr);
         model_step(r, e, thr, afr, bfr);
         check($sformatf("rand%0d", i), m_spd, m_af, m_bf, m_st);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/speed_governor.md
# speed_governor

Parametrised closed-loop speed governor. It integrates applied accelerate and brake forces into a registered speed value. A four-state controller (IDLE/ACCEL/CRUISE/BRAKE) drives that speed toward a programmable threshold, with a hysteresis band, force clamping and saturating arithmetic. It sits between the driver-request inputs and the actuator force outputs, replacing the fixed 8-bit, single-threshold controller.

## Interface
- W, 8: width of speed, threshold, request and force buses.
- STEP, 10: boost added to af_req while accelerating.
- HYST, 4: half-width of the cruise band around threshold.
- MAX_FORCE, 20: upper clamp on o_af and o_bf; must be ≤ 2^W−1.

- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  governor enable; 0 forces IDLE.
- threshold  in  W  target speed, sampled every edge.
- af_req  in  W  driver accelerate request.
- bf_req  in  W  driver brake request.
- speed  out  W  registered integrated speed.
- o_af  out  W  registered accelerate force.
- o_bf  out  W  registered brake force.
- state  out  2  00 IDLE, 01 ACCEL, 10 CRUISE, 11 BRAKE.
- at_target  out  1  high when state==CRUISE.

## Operation
- Reset (rst=1 at an edge): speed=0, o_af=0, o_bf=0, state=IDLE, at_target=0. rst overrides en.
- Every edge with en=1, compute s_n = sat(speed + o_af − o_bf).
  - Compute in W+2 signed bits.
  - Clamp to [0, 2^W−1]; never wrap.
  - speed ← s_n.
- Bounds: lo = max(threshold − HYST, 0); hi = min(threshold + HYST, 2^W−1). Compute in W+1 bits.
- Next state and forces are functions of s_n (the value being written), not of the old speed:
  - s_n < lo → ACCEL: o_af ← min(af_req + STEP, MAX_FORCE), with the sum in W+1 bits; o_bf ← 0.
  - lo ≤ s_n ≤ hi → CRUISE: o_af ← 0, o_bf ← 0.
  - s_n > hi → BRAKE: o_af ← 0; o_bf ← min((s_n − threshold) + bf_req, MAX_FORCE), with the sum in W+1 bits.
- Any state to any state is legal in one edge; there is no dwell requirement.
- Edge with en=0:
  - speed holds.
  - o_af ← 0, o_bf ← 0, state ← IDLE.
  - Forces are not integrated on that edge.
- Leaving IDLE: the first en=1 edge integrates the zero forces (speed unchanged), then classifies.
- Threshold changes take effect on the next edge; no pipeline flush is needed.
- Encodings 00–11 are all used; there is no illegal state.

## Timing
- Speed responds to a force one edge after that force appears on o_af/o_bf.
- state, at_target, o_af and o_bf are mutually consistent and consistent with speed after every edge.
- Force outputs are pure registers; there are no combinational paths from inputs to outputs.
- rst mid-ramp: next edge yields reset values regardless of en or the current state.
- Simultaneous en fall and band crossing: en=0 wins; the result is IDLE.

## Test plan
W=8, STEP=10, HYST=4, MAX_FORCE=20 unless noted.
1. Reset and ramp: rst for 2 edges → all outputs 0, state IDLE. Release with en=1, threshold=100, af_req=0.
   - Edge 1: speed=0, ACCEL, o_af=10.
   - Speed steps 10,20…100.
   - Edge 11: speed=100, CRUISE, at_target=1, o_af=0.
   - Speed holds at 100.
2. Braking: from (1), set threshold=60.
   - Next edge: BRAKE, o_bf=20 (clamped from 40).
   - Then speed 80 with o_bf=20; then speed 60, CRUISE, o_bf=0.
3. Clamp and saturation: threshold=255, speed preloaded to 250 via ramp, af_req=15.
   - o_af=20 (clamped from 25).
   - Next speed=255 (saturated, not 14).
   - State CRUISE.
4. Hysteresis: threshold=100.
   - Speed 97 or 104 → CRUISE.
   - Speed 95 → ACCEL.
   - Speed 105 → BRAKE with o_bf=min(5+bf_req,20).
   - bf_req=30 → o_bf=20.
5. Low-threshold boundary: threshold=2, speed 0 → lo=0, CRUISE (no underflow to ACCEL). en=0 mid-ramp at speed 40 → IDLE, forces 0, speed stays 40.
6. Reset mid-operation: in BRAKE with o_bf=20, assert rst with en=1 → next edge speed=0, o_bf=0, state IDLE.
